// File: rtl/adc_avg_filter_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | adc_avg_filter_if : sample/result bundle for the 4-ch averager   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface adc_avg_filter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in1, in2, in3, in4;
    logic             clear;
    logic [WIDTH-1:0] out1, out2, out3, out4;
    logic             out_valid;
    logic             busy;
    logic             full;
    logic             overrun;

    modport master (
        output in_valid, in1, in2, in3, in4, clear,
        input  out1, out2, out3, out4, out_valid, busy, full, overrun
    );

    modport slave (
        input  in_valid, in1, in2, in3, in4, clear,
        output out1, out2, out3, out4, out_valid, busy, full, overrun
    );
endinterface
`default_nettype wire

// File: rtl/adc_avg_filter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | adc_avg_filter : 4-channel boxcar average, one shared adder      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module adc_avg_filter #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    adc_avg_filter_if.slave  bus
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] PTR_LAST = LOG2_DEPTH'(DEPTH - 1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_UPD  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            ch_q, ch_d;
    logic [LOG2_DEPTH-1:0] ptr_q;
    logic [WIDTH-1:0]      hist_q [4][DEPTH];
    logic [WIDTH-1:0]      samp_q [4];
    logic [WIDTH-1:0]      old_q;
    logic [SW-1:0]         sum_q  [4];
    logic [WIDTH-1:0]      out_q  [4];
    logic                  out_valid_q;
    logic                  full_q;
    logic                  overrun_q;
    logic [SW-1:0]         w_sum_next;

    // The sum already contains the outgoing sample, so this never underflows.
    assign w_sum_next = sum_q[ch_q] + SW'(samp_q[ch_q]) - SW'(old_q);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                state_d = S_RD;
                ch_d    = 2'd0;
            end
            S_RD:   state_d = S_UPD;
            S_UPD:  if (ch_q != 2'd3) begin
                ch_d    = ch_q + 2'd1;
                state_d = S_RD;
            end else begin
                state_d = S_OUT;
            end
            S_OUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.clear) begin
            state_d = S_IDLE;
            ch_d    = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            old_q       <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                samp_q[c] <= '0;
                sum_q[c]  <= '0;
                out_q[c]  <= '0;
                for (int d = 0; d < DEPTH; d++) hist_q[c][d] <= '0;
            end
        end else if (bus.clear) begin
            ptr_q       <= '0;
            old_q       <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                samp_q[c] <= '0;
                sum_q[c]  <= '0;
                out_q[c]  <= '0;
                for (int d = 0; d < DEPTH; d++) hist_q[c][d] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                if (state_q == S_IDLE) begin
                    samp_q[0] <= bus.in1;
                    samp_q[1] <= bus.in2;
                    samp_q[2] <= bus.in3;
                    samp_q[3] <= bus.in4;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            case (state_q)
                S_RD:  old_q <= hist_q[ch_q][ptr_q];
                S_UPD: begin
                    sum_q[ch_q]         <= w_sum_next;
                    hist_q[ch_q][ptr_q] <= samp_q[ch_q];
                end
                S_OUT: begin
                    for (int c = 0; c < 4; c++) out_q[c] <= sum_q[c][SW-1:LOG2_DEPTH];
                    out_valid_q <= 1'b1;
                    ptr_q       <= ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) full_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.out1      = out_q[0];
    assign bus.out2      = out_q[1];
    assign bus.out3      = out_q[2];
    assign bus.out4      = out_q[3];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.full      = full_q;
    assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire
